// File: rtl/rv_pkg.sv
// Shared RV32I definitions used by the fetch stage and by decode, so that the
// two stages agree on instruction encodings, word width and reset defaults.
package rv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- shown to decode whenever fetch has nothing to offer
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Major opcodes (instr[6:0]); decode keys its control unit off instr[6:2]
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // One buffered fetch result: the word and the address it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Instruction fetches are always whole words
    function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries between the
// instruction memory and decode. Flush empties it in one cycle and wins over
// any push or pop issued alongside it.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rdPtr;
    logic [AW-1:0]    r_wrPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPop;
    logic             w_doPush;

    assign w_doPop  = i_pop && !i_flush && (r_count != '0);
    assign w_doPush = i_push && !i_flush && ((r_count != CW'(DEPTH)) || w_doPop);

    // Storage array; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
        end
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rdPtr];

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage. Issues sequential word fetches, tracks how
// many are outstanding, buffers returned words with their PCs for decode, and
// on a redirect throws away both the buffer and every response still owed for
// the old path.
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rstN,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemReqAddr,
    input  logic        imemRspValid,
    input  logic [31:0] imemRspData,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        idValid,
    input  logic        idReady,
    output logic [31:0] idInstr,
    output logic [31:0] idPc,
    output logic [31:0] idPcPlus4,
    output logic        protoErr
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_pcReg;
    logic [31:0]   r_rspPc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_discard;
    logic          r_protoErr;
    logic          r_started;
    logic [31:0]   r_lastPc;

    logic [CW-1:0] w_fifoCount;
    logic          w_fifoEmpty;
    fetch_entry_t  w_head;
    fetch_entry_t  w_pushEntry;
    logic [CW:0]   w_creditsUsed;
    logic          w_reqFire;
    logic          w_rspLegal;
    logic          w_rspLive;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_target;

    // Buffered words plus outstanding requests may never exceed DEPTH, which is
    // what guarantees every response has a FIFO slot waiting for it
    assign w_creditsUsed = {1'b0, w_fifoCount} + {1'b0, r_inflight};
    assign imemReqValid  = r_started && !redirect && (w_creditsUsed < (CW + 1)'(DEPTH));
    assign imemReqAddr   = r_pcReg;
    assign w_reqFire     = imemReqValid && imemReqReady;

    // A response is only legal when something is outstanding; it is live only
    // once all responses belonging to an abandoned path have been dropped
    assign w_rspLegal  = imemRspValid && (r_inflight != '0);
    assign w_rspLive   = w_rspLegal && (r_discard == '0);
    assign w_push      = w_rspLive && !redirect;
    assign w_pop       = !w_fifoEmpty && idReady && !redirect;
    assign w_target    = alignWord(redirectPc);
    assign w_pushEntry = '{pc: r_rspPc, instr: imemRspData};

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstN    (rstN),
        .i_push  (w_push),
        .i_data  (w_pushEntry),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_count (w_fifoCount),
        .o_empty (w_fifoEmpty),
        .o_head  (w_head)
    );

    // PC registers and outstanding/discard counters; a redirect overrides all other updates
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_pcReg    <= RESET_PC;
            r_rspPc    <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
        end else if (redirect) begin
            r_pcReg    <= w_target;
            r_rspPc    <= w_target;
            r_inflight <= r_inflight - CW'(w_rspLegal);
            r_discard  <= r_inflight - CW'(w_rspLegal);
        end else begin
            if (w_reqFire) begin
                r_pcReg <= r_pcReg + 32'd4;
            end
            r_inflight <= r_inflight + CW'(w_reqFire) - CW'(w_rspLegal);
            if (w_rspLegal) begin
                if (r_discard != '0) begin
                    r_discard <= r_discard - CW'(1);
                end else begin
                    r_rspPc <= r_rspPc + 32'd4;
                end
            end
        end
    end

    // Status: request gating out of reset, sticky protocol error, last PC shown to decode
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_started  <= 1'b0;
            r_protoErr <= 1'b0;
            r_lastPc   <= '0;
        end else begin
            r_started <= 1'b1;
            if (imemRspValid && (r_inflight == '0)) begin
                r_protoErr <= 1'b1;
            end
            if (!w_fifoEmpty) begin
                r_lastPc <= w_head.pc;
            end
        end
    end

    assign idValid   = !w_fifoEmpty;
    assign idInstr   = w_fifoEmpty ? NOP_INSTR : w_head.instr;
    assign idPc      = w_fifoEmpty ? r_lastPc : w_head.pc;
    assign idPcPlus4 = idPc + 32'd4;
    assign protoErr  = r_protoErr;

endmodule
